// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART types, default baud divisors and the baud-select decode
package spart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DIV_4800_DEF  = 1302;
  localparam int DIV_9600_DEF  = 651;
  localparam int DIV_19200_DEF = 326;
  localparam int DIV_38400_DEF = 163;
  localparam logic [47:0] DIV_TABLE_DEF = {12'(DIV_38400_DEF), 12'(DIV_19200_DEF), 12'(DIV_9600_DEF), 12'(DIV_4800_DEF)};
  function automatic logic [11:0] br_div(input logic [1:0] br_cfg, input logic [47:0] divs = DIV_TABLE_DEF);
    return divs[br_cfg*12 +: 12];
  endfunction
endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: 16x-oversample enable, one-cycle tick every div clocks
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] div,
  input  logic        restart,
  output logic        tick
);
  logic [11:0] cnt;
  assign tick = cnt == '0;
  // count down to zero, then reload div-1; restart realigns the phase to a frame load
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (restart || tick) ? div - 12'd1 : cnt - 12'd1;
endmodule

// File: rtl/spart_tx.sv
// spart_tx: SPART transmitter, one-byte holding buffer feeding an 8N1 shifter on txd
module spart_tx
  import spart_pkg::*;
#(
  parameter int DIV_4800  = DIV_4800_DEF,
  parameter int DIV_9600  = DIV_9600_DEF,
  parameter int DIV_19200 = DIV_19200_DEF,
  parameter int DIV_38400 = DIV_38400_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       txd
);
  localparam logic [47:0] DIVS = {12'(DIV_38400), 12'(DIV_19200), 12'(DIV_9600), 12'(DIV_4800)};
  tx_state_t   state, state_n;
  logic [7:0]  shift, shift_n, buf_data;
  logic [3:0]  tick_cnt, tick_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [11:0] div_q, div_n;
  logic        buf_full, buf_full_n, txd_n, tick, last, load, accept;
  assign tx_ready = !buf_full;
  assign tx_busy  = state != IDLE;
  spart_baud_gen u_baud (
    .clk    (clk),
    .rst    (rst),
    .div    (div_n),
    .restart(load),
    .tick   (tick)
  );
  // next-state and datapath; a load from STOP chains frames with no idle cycle
  always_comb begin
    accept = tx_valid && !buf_full;
    last = tick && tick_cnt == 4'hf;
    load = buf_full && (state == IDLE || (state == STOP && last));
    state_n = state;
    case (state)
      IDLE:    state_n = buf_full ? START : IDLE;
      START:   state_n = last ? DATA : START;
      DATA:    state_n = (last && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = last ? (buf_full ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
    shift_n = load ? buf_data : (state == DATA && last) ? shift >> 1 : shift;
    div_n = load ? br_div(br_cfg, DIVS) : div_q;
    tick_cnt_n = (load || state == IDLE) ? 4'd0 : tick ? tick_cnt + 4'd1 : tick_cnt;
    bit_idx_n = load ? 3'd0 : (state == DATA && last) ? bit_idx + 3'd1 : bit_idx;
    buf_full_n = accept ? 1'b1 : load ? 1'b0 : buf_full;
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  // state, datapath and buffer registers; reset parks the line high at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      div_q    <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      div_q    <= div_n;
      buf_full <= buf_full_n;
      buf_data <= accept ? tx_data : buf_data;
      txd      <= txd_n;
    end
endmodule
